// File: rtl/window_builder.sv
`default_nettype none
// ============================================================================
//  Module   : window_builder
//  Purpose  : Builds a sliding 3x3 pixel window from three line-memory read
//             words (rows A/B/C). Each accepted word is unpacked one pixel
//             column per cycle into a 3-column shift window. A registered
//             window is issued once three columns of the current line exist.
//  Ports    : clk, rst                 - clock, synchronous active-high reset
//             word_a/b/c               - packed row words, pixel 0 in LSBs
//             word_valid/first/last    - word qualifier and line markers
//             word_ready               - word accepted when valid && ready
//             win_data                 - 3x3 window, (r,k) at (3r+k)*PW
//             win_valid/last/col       - window strobe, line end, column idx
//  Revision : 1.0 - initial release
// ============================================================================
module window_builder #(
    parameter int PIXEL_WIDTH     = 8,
    parameter int PIXELS_PER_WORD = 4,
    parameter int COUNT_WIDTH     = 10
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [PIXEL_WIDTH*PIXELS_PER_WORD-1:0] word_a,
    input  logic [PIXEL_WIDTH*PIXELS_PER_WORD-1:0] word_b,
    input  logic [PIXEL_WIDTH*PIXELS_PER_WORD-1:0] word_c,
    input  logic                                   word_valid,
    input  logic                                   word_first,
    input  logic                                   word_last,
    output logic                                   word_ready,
    output logic [9*PIXEL_WIDTH-1:0]               win_data,
    output logic                                   win_valid,
    output logic                                   win_last,
    output logic [COUNT_WIDTH-1:0]                 win_col
);

    localparam int WORD_W = PIXEL_WIDTH * PIXELS_PER_WORD;
    localparam int WIN_W  = 9 * PIXEL_WIDTH;
    localparam int IDX_W  = (PIXELS_PER_WORD > 1) ? $clog2(PIXELS_PER_WORD) : 1;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PIXELS_PER_WORD - 1);

    logic [0:0]             state_q,     state_d;
    logic [IDX_W-1:0]       pix_idx_q,   pix_idx_d;
    logic [1:0]             fill_q,      fill_d;
    logic [WORD_W-1:0]      hold_a_q,    hold_a_d;
    logic [WORD_W-1:0]      hold_b_q,    hold_b_d;
    logic [WORD_W-1:0]      hold_c_q,    hold_c_d;
    logic                   hold_last_q, hold_last_d;
    logic [WIN_W-1:0]       shift_q,     shift_d;
    logic [WIN_W-1:0]       win_data_q,  win_data_d;
    logic                   win_valid_q, win_valid_d;
    logic                   win_last_q,  win_last_d;
    logic [COUNT_WIDTH-1:0] win_col_q,   win_col_d;

    logic                   w_accept;
    logic                   w_line_end;
    logic [1:0]             w_fill_inc;
    logic [PIXEL_WIDTH-1:0] w_new_px [3];

    // Ready while idle, or while the last pixel of the held word is being
    // shifted so back-to-back words sustain one column per cycle.
    assign word_ready = (state_q == ST_IDLE) || (pix_idx_q == LAST_IDX);
    assign w_accept   = word_valid && word_ready;

    // Newest column pixels taken from the held words at the current index.
    assign w_new_px[0] = hold_a_q[int'(pix_idx_q)*PIXEL_WIDTH +: PIXEL_WIDTH];
    assign w_new_px[1] = hold_b_q[int'(pix_idx_q)*PIXEL_WIDTH +: PIXEL_WIDTH];
    assign w_new_px[2] = hold_c_q[int'(pix_idx_q)*PIXEL_WIDTH +: PIXEL_WIDTH];

    assign w_fill_inc = (fill_q == 2'd3) ? 2'd3 : fill_q + 2'd1;
    assign w_line_end = hold_last_q && (pix_idx_q == LAST_IDX);

    always_comb begin
        state_d     = state_q;
        pix_idx_d   = pix_idx_q;
        fill_d      = fill_q;
        hold_a_d    = hold_a_q;
        hold_b_d    = hold_b_q;
        hold_c_d    = hold_c_q;
        hold_last_d = hold_last_q;
        shift_d     = shift_q;
        win_data_d  = win_data_q;
        win_valid_d = 1'b0;
        win_last_d  = 1'b0;
        win_col_d   = win_col_q;

        if (state_q == ST_SHIFT) begin
            for (int r = 0; r < 3; r++) begin
                shift_d[(3*r)*PIXEL_WIDTH   +: PIXEL_WIDTH] = shift_q[(3*r+1)*PIXEL_WIDTH +: PIXEL_WIDTH];
                shift_d[(3*r+1)*PIXEL_WIDTH +: PIXEL_WIDTH] = shift_q[(3*r+2)*PIXEL_WIDTH +: PIXEL_WIDTH];
                shift_d[(3*r+2)*PIXEL_WIDTH +: PIXEL_WIDTH] = w_new_px[r];
            end

            if (w_fill_inc == 2'd3) begin
                win_valid_d = 1'b1;
                win_last_d  = w_line_end;
                win_data_d  = shift_d;
                // fill was 2 only on the first complete window of a line
                win_col_d   = (fill_q == 2'd2) ? '0 : win_col_q + 1'b1;
            end

            fill_d = w_line_end ? 2'd0 : w_fill_inc;

            if (pix_idx_q == LAST_IDX) begin
                pix_idx_d = '0;
                state_d   = ST_IDLE;
            end else begin
                pix_idx_d = pix_idx_q + 1'b1;
            end
        end

        // Acceptance overrides the idle transition; a line start restarts
        // the fill count after any final shift of the previous word.
        if (w_accept) begin
            hold_a_d    = word_a;
            hold_b_d    = word_b;
            hold_c_d    = word_c;
            hold_last_d = word_last;
            pix_idx_d   = '0;
            state_d     = ST_SHIFT;
            if (word_first) begin
                fill_d = 2'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pix_idx_q   <= '0;
            fill_q      <= 2'd0;
            hold_a_q    <= '0;
            hold_b_q    <= '0;
            hold_c_q    <= '0;
            hold_last_q <= 1'b0;
            shift_q     <= '0;
            win_data_q  <= '0;
            win_valid_q <= 1'b0;
            win_last_q  <= 1'b0;
            win_col_q   <= '0;
        end else begin
            state_q     <= state_d;
            pix_idx_q   <= pix_idx_d;
            fill_q      <= fill_d;
            hold_a_q    <= hold_a_d;
            hold_b_q    <= hold_b_d;
            hold_c_q    <= hold_c_d;
            hold_last_q <= hold_last_d;
            shift_q     <= shift_d;
            win_data_q  <= win_data_d;
            win_valid_q <= win_valid_d;
            win_last_q  <= win_last_d;
            win_col_q   <= win_col_d;
        end
    end

    assign win_data  = win_data_q;
    assign win_valid = win_valid_q;
    assign win_last  = win_last_q;
    assign win_col   = win_col_q;

endmodule
`default_nettype wire

// File: tb/tb_window_builder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_window_builder
//  Purpose  : Self-checking bench for window_builder. A directed vector table
//             covers a single-word line; hand sequences cover back-to-back
//             lines, ignored words and mid-shift reset; random traffic is
//             compared against a column-queue reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_window_builder;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] word_a, word_b, word_c;
    logic        word_valid, word_first, word_last;
    logic        word_ready;
    logic [71:0] win_data;
    logic        win_valid, win_last;
    logic [9:0]  win_col;

    window_builder #(
        .PIXEL_WIDTH(8), .PIXELS_PER_WORD(4), .COUNT_WIDTH(10)
    ) dut (
        .clk(clk), .rst(rst),
        .word_a(word_a), .word_b(word_b), .word_c(word_c),
        .word_valid(word_valid), .word_first(word_first), .word_last(word_last),
        .word_ready(word_ready),
        .win_data(win_data), .win_valid(win_valid), .win_last(win_last),
        .win_col(win_col)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model: a queue of pending pixel columns -----
    typedef struct packed {
        logic [23:0] px;     // row r pixel at [r*8 +: 8]
        logic        first;  // first column of a line-start word
        logic        last;   // last column of a line-end word
    } col_t;

    col_t        colq[$];
    int          line_n;
    logic [7:0]  mw [3][3];
    logic        m_valid, m_last;
    logic [9:0]  m_col;
    logic [71:0] m_data;
    bit          m_known = 0;
    int          dut_wins = 0;
    int          dut_last_col = -1;
    int          dut_first_col = -1;

    task automatic model_edge(input bit r, input bit acc, input bit f, input bit l,
                              input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        col_t cc;
        if (r) begin
            colq.delete();
            line_n  = 0;
            m_valid = 0; m_last = 0; m_col = 0; m_data = '0;
            for (int i = 0; i < 3; i++) for (int k = 0; k < 3; k++) mw[i][k] = 8'h00;
            m_known = 1;
            return;
        end
        m_valid = 0;
        m_last  = 0;
        if (colq.size() > 0) begin
            cc = colq.pop_front();
            if (cc.first) line_n = 0;
            for (int i = 0; i < 3; i++) begin
                mw[i][0] = mw[i][1];
                mw[i][1] = mw[i][2];
                mw[i][2] = cc.px[i*8 +: 8];
            end
            line_n++;
            if (line_n >= 3) begin
                m_valid = 1;
                m_last  = cc.last;
                m_col   = 10'(line_n - 3);
                for (int i = 0; i < 3; i++)
                    for (int k = 0; k < 3; k++)
                        m_data[(3*i+k)*8 +: 8] = mw[i][k];
            end
            if (cc.last) line_n = 0;
        end
        if (acc) begin
            for (int k = 0; k < 4; k++) begin
                cc.px    = {c[k*8 +: 8], b[k*8 +: 8], a[k*8 +: 8]};
                cc.first = f && (k == 0);
                cc.last  = l && (k == 3);
                colq.push_back(cc);
            end
        end
    endtask

    // One clock: check ready, drive inputs, clock, update model, check outputs.
    task automatic step(input bit r, input bit v, input bit f, input bit l,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        bit m_rdy;
        m_rdy = (colq.size() <= 1);
        if (m_known && !r) chk("word_ready", word_ready, m_rdy);
        rst = r; word_valid = v; word_first = f; word_last = l;
        word_a = a; word_b = b; word_c = c;
        @(posedge clk);
        model_edge(r, v && m_rdy, f, l, a, b, c);
        #1;
        chk("win_valid", win_valid, m_valid);
        chk("win_last", win_last, m_last);
        chk("win_data", win_data, m_data);
        if (m_valid) chk("win_col", win_col, m_col);
        if (win_valid === 1'b1) begin
            if (dut_first_col < 0) dut_first_col = int'(win_col);
            dut_wins++;
            dut_last_col = int'(win_col);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, $urandom, $urandom, $urandom);
    endtask

    // Drive words with valid held high and fresh data every cycle until
    // nw words are taken; markers describe word index within the run.
    task automatic burst(input int nw, input int first_at0, input int last_at0,
                         input int first_at1, input int last_at1);
        int  w = 0;
        bit  rdy;
        while (w < nw) begin
            rdy = (colq.size() <= 1);
            step(0, 1, (w == first_at0) || (w == first_at1),
                       (w == last_at0)  || (w == last_at1),
                 $urandom, $urandom, $urandom);
            if (rdy) w++;
        end
    endtask

    // ---------------- directed table -----------------------------------------
    typedef struct {
        bit          r, v, f, l;
        bit          chk_rdy;
        bit          exp_rdy;
        bit          exp_wv, exp_wl;
        logic [9:0]  exp_col;
        logic [71:0] exp_data;
    } vec_t;

    vec_t tbl[7];
    int   w0;

    initial begin
        rst = 1'b1; word_valid = 0; word_first = 0; word_last = 0;
        word_a = '0; word_b = '0; word_c = '0;

        tbl[0] = '{1, 0, 0, 0, 0, 0, 0, 0, 10'd0, 72'h0};
        tbl[1] = '{0, 1, 1, 1, 1, 1, 0, 0, 10'd0, 72'h0};
        tbl[2] = '{0, 0, 0, 0, 1, 0, 0, 0, 10'd0, 72'h0};
        tbl[3] = '{0, 0, 0, 0, 1, 0, 0, 0, 10'd0, 72'h0};
        tbl[4] = '{0, 0, 0, 0, 1, 0, 1, 0, 10'd0, 72'h23_22_21_13_12_11_03_02_01};
        tbl[5] = '{0, 0, 0, 0, 1, 1, 1, 1, 10'd1, 72'h24_23_22_14_13_12_04_03_02};
        tbl[6] = '{0, 0, 0, 0, 1, 1, 0, 0, 10'd0, 72'h24_23_22_14_13_12_04_03_02};

        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 7; i++) begin
            if (tbl[i].chk_rdy) chk("tbl_ready", word_ready, tbl[i].exp_rdy);
            step(tbl[i].r, tbl[i].v, tbl[i].f, tbl[i].l,
                 32'h04030201, 32'h14131211, 32'h24232221);
            chk("tbl_win_valid", win_valid, tbl[i].exp_wv);
            chk("tbl_win_last", win_last, tbl[i].exp_wl);
            chk("tbl_win_data", win_data, tbl[i].exp_data);
            if (tbl[i].exp_wv) chk("tbl_win_col", win_col, tbl[i].exp_col);
        end

        // Three-word line, valid held with changing data: 10 windows, col 0..9.
        w0 = dut_wins;
        burst(3, 0, 2, -1, -1);
        idle(6);
        chk("line3_windows", 72'(dut_wins - w0), 72'd10);
        chk("line3_last_col", 72'(dut_last_col), 72'd9);

        // Two lines back-to-back (2 words each): 6 + 6 windows.
        w0 = dut_wins;
        burst(4, 0, 1, 2, 3);
        idle(6);
        chk("two_lines_windows", 72'(dut_wins - w0), 72'd12);

        // Reset while pix_idx == 2, then a fresh one-word line.
        step(0, 1, 1, 0, $urandom, $urandom, $urandom);
        idle(2);
        step(1, 0, 0, 0, $urandom, $urandom, $urandom);
        chk("rst_win_valid", win_valid, 1'b0);
        chk("rst_win_data", win_data, 72'h0);
        chk("rst_word_ready", word_ready, 1'b1);
        dut_first_col = -1;
        w0 = dut_wins;
        step(0, 1, 1, 1, $urandom, $urandom, $urandom);
        idle(6);
        chk("post_rst_windows", 72'(dut_wins - w0), 72'd2);
        chk("post_rst_first_col", 72'(dut_first_col), 72'd0);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 300) == 0, ($urandom % 3) != 0,
                 ($urandom % 6) == 0, ($urandom % 5) == 0,
                 $urandom, $urandom, $urandom);
        end
        idle(6);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
